// File: rtl/decay_envelope.sv
// Per-voice amplitude-decay controller feeding an e^-x exponent stage.
// One exponent request per sample tick; the 0.8 result becomes the voice gain.
module decay_envelope #(
   parameter int TICK_CYCLES = 2083,
   parameter int RATE_SHIFT  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger,
   input  logic [7:0]  decay_rate,
   output logic        exp_in_valid,
   output logic [11:0] exp_in_value,
   input  logic        exp_out_valid,
   input  logic [7:0]  exp_out_value,
   output logic        env_valid,
   output logic [7:0]  env_value,
   output logic        active
);
   localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] tick_cnt_reg;
   logic          tick;
   logic [15:0]   elapsed_reg, elapsed_next, elapsed_inc;
   logic          stale_reg, stale_next;
   logic [23:0]   product, shifted;
   logic [11:0]   x;
   logic          exp_in_valid_next, env_valid_next, active_next;
   logic [11:0]   exp_in_value_next;
   logic [7:0]    env_value_next;

   assign tick = (tick_cnt_reg == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       tick_cnt_reg <= '0;
      else if (tick) tick_cnt_reg <= '0;
      else           tick_cnt_reg <= tick_cnt_reg + CW'(1);
   end

   // The request argument uses the elapsed count as it will be after this tick.
   always_comb begin
      elapsed_inc = (elapsed_reg == 16'hFFFF) ? elapsed_reg : elapsed_reg + 16'd1;
      product     = {8'd0, elapsed_inc} * {16'd0, decay_rate};
      shifted     = product >> RATE_SHIFT;
      x           = (shifted > 24'h000FFF) ? 12'hFFF : shifted[11:0];
   end

   always_comb begin
      state_next        = state_reg;
      elapsed_next      = elapsed_reg;
      stale_next        = stale_reg;
      active_next       = active;
      env_value_next    = env_value;
      env_valid_next    = 1'b0;
      exp_in_valid_next = 1'b0;
      exp_in_value_next = exp_in_value;

      if (active && tick) elapsed_next = elapsed_inc;

      case (state_reg)
         HOLD: begin
            if (tick) begin
               if (x == 12'h000) begin
                  // e^0 = 1.0 is not representable in 0.8, so full scale is applied locally.
                  env_value_next = 8'hFF;
                  env_valid_next = 1'b1;
               end else if (x >= 12'h800) begin
                  env_value_next = 8'h00;
                  env_valid_next = 1'b1;
                  active_next    = 1'b0;
                  state_next     = IDLE;
               end else begin
                  exp_in_valid_next = 1'b1;
                  exp_in_value_next = x;
                  state_next        = BUSY;
               end
            end
         end
         BUSY: begin
            if (exp_out_valid && !stale_reg) begin
               env_value_next = exp_out_value;
               env_valid_next = 1'b1;
               state_next     = HOLD;
            end
         end
         default: ;
      endcase

      // Results come back in order, so a stale result is always the next to arrive.
      if (exp_out_valid && stale_reg) stale_next = 1'b0;

      if (trigger) begin
         state_next        = HOLD;
         elapsed_next      = 16'd0;
         active_next       = 1'b1;
         env_value_next    = 8'hFF;
         env_valid_next    = 1'b1;
         exp_in_valid_next = 1'b0;
         exp_in_value_next = exp_in_value;
         if (state_reg == BUSY) stale_next = stale_reg || !exp_out_valid;
         else                   stale_next = stale_reg && !exp_out_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         elapsed_reg  <= 16'd0;
         stale_reg    <= 1'b0;
         active       <= 1'b0;
         env_value    <= 8'h00;
         env_valid    <= 1'b0;
         exp_in_valid <= 1'b0;
         exp_in_value <= 12'h000;
      end else begin
         state_reg    <= state_next;
         elapsed_reg  <= elapsed_next;
         stale_reg    <= stale_next;
         active       <= active_next;
         env_value    <= env_value_next;
         env_valid    <= env_valid_next;
         exp_in_valid <= exp_in_valid_next;
         exp_in_value <= exp_in_value_next;
      end
   end
endmodule

// File: tb/tb_decay_envelope.sv
// Directed bench for decay_envelope: a scoreboard holds expected requests and gain
// updates, and a monitor pops and compares them whenever the design emits one.
module tb_decay_envelope;
   localparam int TICK = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trigger = 1'b0;
   logic [7:0]  decay_rate = 8'h00;
   logic        exp_out_valid = 1'b0;
   logic [7:0]  exp_out_value = 8'h00;
   logic        exp_in_valid, env_valid, active;
   logic [11:0] exp_in_value;
   logic [7:0]  env_value;

   int compared = 0;
   int mismatched = 0;
   int req_seen = 0;
   logic [11:0] req_q[$];
   logic [7:0]  env_q[$];
   logic [11:0] mon_x;
   logic [7:0]  mon_e;

   decay_envelope #(.TICK_CYCLES(TICK), .RATE_SHIFT(0)) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .decay_rate(decay_rate),
      .exp_in_valid(exp_in_valid), .exp_in_value(exp_in_value),
      .exp_out_valid(exp_out_valid), .exp_out_value(exp_out_value),
      .env_valid(env_valid), .env_value(env_value), .active(active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      compared++;
      assert (obs === want) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Exponent-stage reference: floor(256 * e^-(x/256)), clipped to 0.8 range.
   function automatic logic [7:0] exp_model(input int xv);
      real r;
      r = 256.0 * $exp(-real'(xv) / 256.0);
      if (r >= 255.0) return 8'hFF;
      return 8'($rtoi(r));
   endfunction

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (exp_in_valid) begin
            req_seen++;
            check("req_expected", 32'(req_q.size() > 0), 1);
            if (req_q.size() > 0) begin
               mon_x = req_q.pop_front();
               $display("request x=%03h expected=%03h", exp_in_value, mon_x);
               check("req_x", 32'(exp_in_value), 32'(mon_x));
            end
         end
         if (env_valid) begin
            check("env_expected", 32'(env_q.size() > 0), 1);
            if (env_q.size() > 0) begin
               mon_e = env_q.pop_front();
               $display("env update value=%02h expected=%02h", env_value, mon_e);
               check("env_value", 32'(env_value), 32'(mon_e));
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input string tag);
      int start;
      start = req_seen;
      for (int i = 0; i < 200 && req_seen == start; i++) @(negedge clk);
      check(tag, 32'(req_seen != start), 1);
   endtask

   task automatic wait_env(input string tag);
      for (int i = 0; i < 200 && env_q.size() != 0; i++) @(negedge clk);
      check(tag, 32'(env_q.size()), 0);
   endtask

   task automatic pulse_trigger(input string tag);
      env_q.push_back(8'hFF);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      check(tag, 32'(env_q.size()), 0);
   endtask

   task automatic respond(input string tag, input logic [7:0] v, input bit accept);
      if (accept) env_q.push_back(v);
      exp_out_valid = 1'b1;
      exp_out_value = v;
      @(negedge clk);
      exp_out_valid = 1'b0;
      check(tag, 32'(env_q.size()), 0);
   endtask

   initial begin
      int seen0;
      cycles(3);
      check("rst_exp_in_valid", 32'(exp_in_valid), 0);
      check("rst_exp_in_value", 32'(exp_in_value), 0);
      check("rst_env_valid", 32'(env_valid), 0);
      check("rst_env_value", 32'(env_value), 0);
      check("rst_active", 32'(active), 0);
      rst = 1'b0;

      // Idle for ten ticks, then a result strobe that must be ignored
      cycles(10 * TICK);
      check("t1_env_value", 32'(env_value), 0);
      check("t1_active", 32'(active), 0);
      check("t1_no_req", 32'(req_seen), 0);
      respond("t1_ignored_result", 8'h77, 1'b0);
      check("t1_env_after_stray", 32'(env_value), 0);

      // Basic decay: first two requests
      decay_rate = 8'h10;
      pulse_trigger("t2_trig_env");
      check("t2_active", 32'(active), 1);
      check("t2_env_ff", 32'(env_value), 32'h0FF);
      req_q.push_back(12'h010);
      wait_req("t2_req1_seen");
      cycles(2);
      respond("t2_resp1", 8'hF0, 1'b1);
      check("t2_env_f0", 32'(env_value), 32'h0F0);
      req_q.push_back(12'h020);
      wait_req("t2_req2_seen");
      cycles(2);
      respond("t2_resp2", exp_model(32'h020), 1'b1);

      // Run until x reaches 12'h800
      for (int e = 3; e < 128; e++) begin
         req_q.push_back(12'(e * 16));
         wait_req("t3_req_seen");
         cycles(2);
         respond("t3_resp", exp_model(e * 16), 1'b1);
      end
      env_q.push_back(8'h00);
      wait_env("t3_env_zero");
      check("t3_active_off", 32'(active), 0);
      check("t3_env_value", 32'(env_value), 0);
      seen0 = req_seen;
      cycles(3 * TICK);
      check("t3_no_more_req", 32'(req_seen), 32'(seen0));

      // Slow exponent stage: two ticks skipped while busy
      pulse_trigger("t4_trig_env");
      req_q.push_back(12'h010);
      wait_req("t4_req1_seen");
      seen0 = req_seen;
      cycles(130);
      check("t4_single_req", 32'(req_seen), 32'(seen0));
      respond("t4_resp", exp_model(32'h010), 1'b1);
      req_q.push_back(12'h040);
      wait_req("t4_req_after_skip");

      // Retrigger while busy: stale result discarded
      pulse_trigger("t5_trig_env");
      req_q.push_back(12'h010);
      cycles(2);
      respond("t5_stale_result", 8'h55, 1'b0);
      check("t5_env_hold", 32'(env_value), 32'h0FF);
      wait_req("t5_req_seen");

      // Trigger and result in the same cycle: trigger wins
      env_q.push_back(8'hFF);
      trigger = 1'b1;
      exp_out_valid = 1'b1;
      exp_out_value = 8'h99;
      @(negedge clk);
      trigger = 1'b0;
      exp_out_valid = 1'b0;
      check("t5b_env_pulse", 32'(env_q.size()), 0);
      check("t5b_env_ff", 32'(env_value), 32'h0FF);
      req_q.push_back(12'h010);
      wait_req("t5b_req_seen");
      cycles(2);
      respond("t5b_resp_accepted", exp_model(32'h010), 1'b1);

      // Zero decay rate holds full scale without requests
      decay_rate = 8'h00;
      pulse_trigger("t6_trig_env");
      seen0 = req_seen;
      for (int i = 0; i < 20; i++) begin
         env_q.push_back(8'hFF);
         wait_env("t6_env_tick");
         check("t6_env_ff", 32'(env_value), 32'h0FF);
      end
      check("t6_no_req", 32'(req_seen), 32'(seen0));
      check("t6_active", 32'(active), 1);

      // Reset while a request is outstanding
      decay_rate = 8'h10;
      pulse_trigger("t6b_trig_env");
      req_q.push_back(12'h010);
      wait_req("t6b_req_seen");
      rst = 1'b1;
      cycles(2);
      check("t6b_rst_active", 32'(active), 0);
      check("t6b_rst_env", 32'(env_value), 0);
      check("t6b_rst_exp_in_value", 32'(exp_in_value), 0);
      rst = 1'b0;
      respond("t6b_late_result", 8'h33, 1'b0);
      check("t6b_env_after_late", 32'(env_value), 0);
      seen0 = req_seen;
      cycles(3 * TICK);
      check("t6b_no_req", 32'(req_seen), 32'(seen0));
      check("t6b_active", 32'(active), 0);
      check("end_req_q_empty", 32'(req_q.size()), 0);
      check("end_env_q_empty", 32'(env_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
